// File: rtl/rv32_pkg.sv
// Shared decode-side types: latency classes, register index width and the
// bundled decode request used by the hazard scoreboard.
package rv32_pkg;

  localparam int REG_IDX_W = 5;

  typedef enum logic [1:0] {
    LAT_ALU  = 2'd0,
    LAT_LOAD = 2'd1,
    LAT_LONG = 2'd2,
    LAT_RSVD = 2'd3
  } lat_class_e;

  // Decode-stage fields grouped so a later decode refactor can pass one bus.
  typedef struct packed {
    logic                 valid;
    logic [REG_IDX_W-1:0] rs1;
    logic                 rs1_used;
    logic [REG_IDX_W-1:0] rs2;
    logic                 rs2_used;
    logic [REG_IDX_W-1:0] rd;
    logic                 rd_wr;
    lat_class_e           lat;
  } hz_req_t;

  // The reserved class behaves exactly like a long op.
  function automatic logic is_long(input lat_class_e l);
    return (l == LAT_LONG) || (l == LAT_RSVD);
  endfunction

endpackage

// File: rtl/hz_flush_timer.sv
// Control-hazard flush timer: a redirect (re)loads the counter, which then
// counts down; flush is asserted on the redirect cycle and while nonzero.
module hz_flush_timer #(
  parameter int FLUSH_CYC = 2
) (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic redirect_i,
  output logic flush_o,
  output logic flush_active_o
);

  localparam logic [1:0] LOAD_VAL = 2'(FLUSH_CYC);

  logic [1:0] r_cnt;

  // Countdown register; a new redirect always restarts the full window.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_cnt <= 2'd0;
    end else if (redirect_i) begin
      r_cnt <= LOAD_VAL;
    end else if (r_cnt != 2'd0) begin
      r_cnt <= r_cnt - 2'd1;
    end
  end

  assign flush_active_o = (r_cnt != 2'd0);
  assign flush_o        = flush_active_o | redirect_i;

endmodule

// File: rtl/hazard_scoreboard.sv
// Decode-stage hazard unit: per-register busy scoreboard for loads and
// multi-cycle ops, outstanding long-op counter, stall and flush generation.
module hazard_scoreboard
  import rv32_pkg::*;
#(
  parameter int NREGS     = 32,
  parameter int MAX_LONG  = 2,
  parameter int FLUSH_CYC = 2
) (
  input  logic                 clk_i,
  input  logic                 rst_ni,
  input  logic                 id_valid_i,
  input  logic [REG_IDX_W-1:0] id_rs1_i,
  input  logic [REG_IDX_W-1:0] id_rs2_i,
  input  logic                 id_rs1_used_i,
  input  logic                 id_rs2_used_i,
  input  logic [REG_IDX_W-1:0] id_rd_i,
  input  logic                 id_rd_wr_i,
  input  logic [1:0]           id_lat_i,
  input  logic                 wb_valid_i,
  input  logic [REG_IDX_W-1:0] wb_rd_i,
  input  logic                 wb_long_i,
  input  logic                 ex_redirect_i,
  output logic                 id_stall_o,
  output logic                 flush_o,
  output logic [1:0]           control_hazard_o,
  output logic [NREGS-1:0]     busy_o,
  output logic [31:0]          stall_cnt_o
);

  localparam logic [2:0] LONG_MAX = 3'(MAX_LONG);

  hz_req_t          w_req;
  logic [NREGS-1:0] r_busy;
  logic [NREGS-1:0] w_busy_next;
  logic [NREGS-1:0] w_set_mask;
  logic [NREGS-1:0] w_clr_mask;
  logic [2:0]       r_long_cnt;
  logic [2:0]       w_long_cnt_next;
  logic [31:0]      r_stall_cnt;
  logic             w_redirect;
  logic             w_flush;
  logic             w_flush_active;
  logic             w_long_wb;
  logic             w_req_long;
  logic             w_raw;
  logic             w_waw;
  logic             w_str;
  logic             w_issue;
  logic             w_set_en;
  logic             w_long_inc;

  assign w_req.valid    = id_valid_i;
  assign w_req.rs1      = id_rs1_i;
  assign w_req.rs1_used = id_rs1_used_i;
  assign w_req.rs2      = id_rs2_i;
  assign w_req.rs2_used = id_rs2_used_i;
  assign w_req.rd       = id_rd_i;
  assign w_req.rd_wr    = id_rd_wr_i;
  assign w_req.lat      = lat_class_e'(id_lat_i);

  // Redirect is masked while in reset so every output reads zero then.
  assign w_redirect = ex_redirect_i & rst_ni;

  hz_flush_timer #(
    .FLUSH_CYC(FLUSH_CYC)
  ) u_flush_timer (
    .clk_i          (clk_i),
    .rst_ni         (rst_ni),
    .redirect_i     (w_redirect),
    .flush_o        (w_flush),
    .flush_active_o (w_flush_active)
  );

  assign w_long_wb  = wb_valid_i & wb_long_i;
  assign w_req_long = is_long(w_req.lat);

  // Hazards use the registered scoreboard only; a same-cycle writeback is
  // covered by the register file's write-then-read in the following cycle.
  assign w_raw = (w_req.rs1_used & r_busy[w_req.rs1]) |
                 (w_req.rs2_used & r_busy[w_req.rs2]);
  assign w_waw = w_req.rd_wr & (w_req.rd != '0) & r_busy[w_req.rd];
  assign w_str = w_req_long & (r_long_cnt == LONG_MAX) & ~w_long_wb;

  assign id_stall_o = w_req.valid & (w_raw | w_waw | w_str) & ~w_flush & ~w_redirect;
  assign w_issue    = w_req.valid & ~id_stall_o & ~w_flush;
  assign w_set_en   = w_issue & (w_req.lat != LAT_ALU) & w_req.rd_wr & (w_req.rd != '0);
  assign w_long_inc = w_issue & w_req_long;

  // Per-register set/clear masks; x0 can never become busy.
  genvar gi;
  generate
    for (gi = 0; gi < NREGS; gi++) begin : g_busy
      if (gi == 0) begin : g_x0
        assign w_set_mask[gi]  = 1'b0;
        assign w_clr_mask[gi]  = 1'b0;
        assign w_busy_next[gi] = 1'b0;
      end else begin : g_xn
        assign w_set_mask[gi]  = w_set_en & (w_req.rd == REG_IDX_W'(gi));
        assign w_clr_mask[gi]  = wb_valid_i & (wb_rd_i == REG_IDX_W'(gi));
        assign w_busy_next[gi] = (r_busy[gi] & ~w_clr_mask[gi]) | w_set_mask[gi];
      end
    end
  endgenerate

  // Outstanding long-op count: simultaneous inc/dec cancel, underflow holds 0.
  always_comb begin
    w_long_cnt_next = r_long_cnt;
    if (w_long_inc && !w_long_wb) begin
      w_long_cnt_next = r_long_cnt + 3'd1;
    end else if (!w_long_inc && w_long_wb && (r_long_cnt != 3'd0)) begin
      w_long_cnt_next = r_long_cnt - 3'd1;
    end
  end

  // Scoreboard and long-op counter state.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_busy     <= '0;
      r_long_cnt <= 3'd0;
    end else begin
      r_busy     <= w_busy_next;
      r_long_cnt <= w_long_cnt_next;
    end
  end

  // Saturating count of stalled decode cycles.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_stall_cnt <= 32'd0;
    end else if (id_stall_o && (r_stall_cnt != 32'hFFFF_FFFF)) begin
      r_stall_cnt <= r_stall_cnt + 32'd1;
    end
  end

  assign flush_o          = w_flush;
  assign control_hazard_o = {w_redirect, w_flush_active};
  assign busy_o           = r_busy;
  assign stall_cnt_o      = r_stall_cnt;

  // WAW stalling should make a same-register set and clear impossible.
  a_no_set_clr: assert property (@(posedge clk_i) disable iff (!rst_ni)
    (w_set_mask & w_clr_mask) == '0);

  // A long writeback with nothing outstanding indicates an upstream bug.
  a_no_underflow: assert property (@(posedge clk_i) disable iff (!rst_ni)
    !(w_long_wb && (r_long_cnt == 3'd0)));

endmodule

// File: doc/hazard_scoreboard.md
Name: hazard_scoreboard

Overview:
- Sequences the decode stage: per-register scoreboard tracking in-flight non-forwardable writes (loads, multi-cycle MUL/DIV).
- Produces the decode stall and control-hazard flush signals.
- Sits beside decode; reads decode's source/destination fields, observes writeback and execute-stage branch redirects.
- ALU results are forwarded and never stall.

Parameters:
- NREGS, 32, architectural registers; x0 hard-wired zero.
- MAX_LONG, 2, maximum outstanding multi-cycle ops; range 1..7.
- FLUSH_CYC, 2, cycles flush is held after a redirect; range 1..3.

Ports:
- clk_i  in  1  clock
- rst_ni  in  1  asynchronous active-low reset
- id_valid_i  in  1  decode holds a valid instruction
- id_rs1_i  in  5  source 1 index
- id_rs2_i  in  5  source 2 index
- id_rs1_used_i  in  1  rs1 is read
- id_rs2_used_i  in  1  rs2 is read
- id_rd_i  in  5  destination index
- id_rd_wr_i  in  1  instruction writes rd
- id_lat_i  in  2  latency class: 0 ALU, 1 load, 2 long, 3 reserved (treated as long)
- wb_valid_i  in  1  writeback of a load/long result this cycle
- wb_rd_i  in  5  writeback destination
- wb_long_i  in  1  writeback is a long op
- ex_redirect_i  in  1  branch/jump mispredict resolved in EX
- id_stall_o  out  1  hold IF/ID; combinational
- flush_o  out  1  squash IF and ID
- control_hazard_o  out  2  {redirect-this-cycle, flush-active}
- busy_o  out  NREGS  scoreboard vector, debug
- stall_cnt_o  out  32  saturating count of stalled cycles

Behaviour:
- Reset (async, rst_ni low):
  - busy_o = 0, long_cnt = 0, flush counter = 0.
  - flush_o = 0, control_hazard_o = 0, stall_cnt_o = 0, id_stall_o = 0.
- RAW hazard: raw = (rs1_used & busy[rs1]) | (rs2_used & busy[rs2]).
- WAW hazard: waw = rd_wr & rd != 0 & busy[rd]. Holds ordering when two writers target one register.
- Structural hazard: str = (lat >= 2) & long_cnt == MAX_LONG & no long writeback this cycle.
- id_stall_o = id_valid_i & (raw | waw | str) & !flush_o & !ex_redirect_i. This is combinational, same cycle.
- Issue condition: id_valid_i & !id_stall_o & !flush_o & !ex_redirect_i.
  - On issue with lat != 0, rd_wr and rd != 0: busy[rd] set at the next edge.
  - If lat >= 2, long_cnt also increments.
  - A load or long op with rd == 0 never sets busy; a long op still counts.
- Writeback:
  - wb_valid_i & wb_rd_i != 0 clears busy[wb_rd] at the next edge.
  - wb_long_i decrements long_cnt, including when rd == 0.
  - The same-cycle clear is not visible to id_stall_o. Stall releases one cycle after writeback, because the register file write-then-read covers that cycle.
- Simultaneous set and clear of the same register: set wins. In practice WAW prevents this; assertion-checked.
- Simultaneous long_cnt increment and decrement: count unchanged.
- long_cnt underflow (wb_long_i with count 0) is an error: assertion, count held at 0.
- Redirect and flush:
  - ex_redirect_i loads the flush counter with FLUSH_CYC.
  - flush_o = (counter != 0) | ex_redirect_i.
  - The counter decrements each cycle to 0.
  - A redirect while the counter is nonzero reloads it to FLUSH_CYC.
  - Redirect does not modify busy or long_cnt: in-flight ops are older than the branch and still write back.
- control_hazard_o[1] = ex_redirect_i; control_hazard_o[0] = counter != 0.
- stall_cnt_o increments on each cycle id_stall_o = 1 and saturates at 0xFFFF_FFFF.

Decomposition:
- rv32_pkg additions:
  - lat_class_e enum (LAT_ALU = 0, LAT_LOAD = 1, LAT_LONG = 2, LAT_RSVD = 3).
  - REG_IDX_W = 5 localparam.
  - hz_req_t struct bundling the id_* fields for a later decode refactor.
- One sub-module, hz_flush_timer: counter plus load/reload logic producing flush_o and control_hazard_o[0].
- The scoreboard and hazard compare stay in the top.

Test Plan:
- Load-use: issue load rd = 5 (lat 1); next cycle ADD rs1 = 5 valid.
  - Required: id_stall_o = 1 until the cycle after wb_valid_i with wb_rd_i = 5, then 0.
  - busy_o[5] goes 1 then 0; stall_cnt_o equals the stalled cycles.
- x0 destination: load with rd = 0, then a reader of rs1 = 0.
  - Required: busy_o stays 0; id_stall_o = 0.
- Structural: MAX_LONG = 2; issue two long ops rd = 3 and rd = 4; third long op rd = 6.
  - Required: stalls.
  - wb_long_i with rd = 3 releases it in the same cycle, long_cnt = 2 → stays 2.
- WAW: long op rd = 7 in flight; load rd = 7 presented.
  - Required: stall until the rd = 7 writeback completes, then issue sets busy_o[7] again.
- Redirect during stall: RAW stall active, ex_redirect_i pulses one cycle.
  - Required: id_stall_o = 0 that cycle; flush_o = 1 for 1 + FLUSH_CYC = 3 cycles.
  - control_hazard_o = 2'b10/2'b11 then 2'b01, 2'b01, 2'b00; busy_o unchanged.
- Async reset mid-operation: rst_ni low with busy_o = 0x0000_00A0 and flush active.
  - Required: all outputs 0 immediately, without waiting for a clock edge.
  - After release, a reader of rs1 = 5 does not stall.
